// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared types and constants for the ALU operand sequencer.
//   state_t  : sequencer states (collect A, collect B, collect op,
//              one-cycle execute, show result)
//   OP_*     : 2-bit operation encodings driven onto the ALU select lines
//   PHASE_*  : one-hot LED patterns shown for each phase
// ---------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [2:0] {
        S_A,
        S_B,
        S_OP,
        S_EXEC,
        S_SHOW
    } state_t;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_SHL = 2'b10;
    localparam logic [1:0] OP_AND = 2'b11;

    localparam logic [3:0] PHASE_A    = 4'b0001;
    localparam logic [3:0] PHASE_B    = 4'b0010;
    localparam logic [3:0] PHASE_OP   = 4'b0100;
    localparam logic [3:0] PHASE_SHOW = 4'b1000;

endpackage

// File: rtl/btn_debounce.sv
// ---------------------------------------------------------------------------
// btn_debounce
// Conditions one raw push-button: two-flop synchronizer, stability counter
// and a rising-edge pulse of the debounced level.
// Ports:
//   clk     : system clock
//   rst     : synchronous active-high reset
//   btn_raw : raw, asynchronous, bouncy button level
//   pulse   : one-cycle pulse per accepted press (none on release)
// ---------------------------------------------------------------------------
module btn_debounce #(
    parameter int DB_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic pulse
);

    localparam int CNT_W = $clog2(DB_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             db_q;
    logic             db_prev_q;
    logic [CNT_W-1:0] cnt_q;

    // The level flips on the edge where the counter would reach DB_CYCLES,
    // so exactly DB_CYCLES consecutive differing synchronized cycles are
    // needed. Any cycle where the synchronized level agrees with the
    // debounced level restarts the count, which swallows short bounces.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b00;
            db_q      <= 1'b0;
            db_prev_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            sync_q    <= {sync_q[0], btn_raw};
            db_prev_q <= db_q;
            if (sync_q[1] == db_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                db_q  <= ~db_q;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign pulse = db_q & ~db_prev_q;

endmodule

// File: rtl/alu_operand_sequencer.sv
// ---------------------------------------------------------------------------
// alu_operand_sequencer
// Front-end for the board's 4-bit ALU. Operand A, operand B and the
// operation are loaded from the data switches one per step press; the ALU
// result is captured one cycle after the operation is loaded and held.
// Ports:
//   clk, rst     : clock and synchronous active-high reset
//   sw_data      : raw data switches (quasi-static)
//   btn_step     : raw step button
//   btn_clear    : raw clear button (restarts the sequence)
//   alu_f        : combinational ALU result
//   alu_a/alu_b  : registered operands to the ALU
//   alu_s        : registered op select ([1]=class, [0]=mode)
//   result_q     : captured ALU result
//   result_valid : result_q belongs to the current operand set
//   phase        : one-hot LED phase {SHOW, OP, B, A}
// ---------------------------------------------------------------------------
module alu_operand_sequencer
    import alu_pkg::*;
#(
    parameter int DB_CYCLES = 500000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] sw_data,
    input  logic       btn_step,
    input  logic       btn_clear,
    input  logic [3:0] alu_f,
    output logic [3:0] alu_a,
    output logic [3:0] alu_b,
    output logic [1:0] alu_s,
    output logic [3:0] result_q,
    output logic       result_valid,
    output logic [3:0] phase
);

    logic       step_pulse;
    logic       clear_pulse;
    state_t     state_q;
    state_t     state_d;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [1:0] op_q;

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .pulse   (step_pulse)
    );

    btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_clear),
        .pulse   (clear_pulse)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_A;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and phase decode. Clear wins over a simultaneous step;
    // S_EXEC always lasts one cycle, so steps arriving then are dropped.
    always_comb begin
        state_d = state_q;
        phase   = PHASE_A;
        case (state_q)
            S_A:     begin phase = PHASE_A;    if (step_pulse) state_d = S_B;    end
            S_B:     begin phase = PHASE_B;    if (step_pulse) state_d = S_OP;   end
            S_OP:    begin phase = PHASE_OP;   if (step_pulse) state_d = S_EXEC; end
            S_EXEC:  begin phase = PHASE_OP;   state_d = S_SHOW;                 end
            S_SHOW:  begin phase = PHASE_SHOW; if (step_pulse) state_d = S_A;    end
            default: begin phase = PHASE_A;    state_d = S_A;                    end
        endcase
        if (clear_pulse) begin
            state_d = S_A;
        end
    end

    // Datapath registers. They only load on their capturing edge so the ALU
    // inputs stay glitch-free; operands survive S_SHOW -> S_A until reloaded.
    always_ff @(posedge clk) begin
        if (rst || clear_pulse) begin
            a_q          <= 4'h0;
            b_q          <= 4'h0;
            op_q         <= 2'b00;
            result_q     <= 4'h0;
            result_valid <= 1'b0;
        end else begin
            case (state_q)
                S_A:    if (step_pulse) a_q  <= sw_data;
                S_B:    if (step_pulse) b_q  <= sw_data;
                S_OP:   if (step_pulse) op_q <= sw_data[1:0];
                S_EXEC: begin
                    result_q     <= alu_f;
                    result_valid <= 1'b1;
                end
                S_SHOW: if (step_pulse) result_valid <= 1'b0;
                default: ;
            endcase
        end
    end

    assign alu_a = a_q;
    assign alu_b = b_q;
    assign alu_s = op_q;

endmodule

// File: doc/alu_operand_sequencer.md
Name: alu_operand_sequencer

Overview:
- Upstream front-end for the 4-bit ALU on the board.
- Collects operand A, operand B and the 2-bit operation from the 4 data switches, one item per debounced step-button press, and drives registered, stable values onto the ALU inputs.
- Captures the ALU's combinational result one cycle after the operation is loaded and holds it for display until the next sequence starts.

Parameters:
- DB_CYCLES, 500000: consecutive stable synchronized cycles required before a button level is accepted. Benches override it to 4.
- CNT_W, $clog2(DB_CYCLES+1): width of the debounce counter. Derived; never overridden.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- sw_data  input  4  raw data switches (asynchronous to clk, but treated as quasi-static).
- btn_step  input  1  raw step push-button (asynchronous, bouncy).
- btn_clear  input  1  raw clear push-button (asynchronous, bouncy).
- alu_f  input  4  combinational result returned from the ALU.
- alu_a  output  4  operand A to the ALU (register a_q).
- alu_b  output  4  operand B to the ALU (register b_q).
- alu_s  output  2  op select to the ALU (register op_q): [1]=class, [0]=mode.
- result_q  output  4  captured ALU result.
- result_valid  output  1  result_q holds a result of the current operand set.
- phase  output  4  one-hot current phase for LEDs: [0]=A, [1]=B, [2]=OP, [3]=SHOW.

Behaviour:
- Reset (rst=1 at a clk edge) clears a_q, b_q, op_q, result_q and result_valid to 0, sets state to S_A and phase to 4'b0001. Debouncers clear: synchronizers 0, debounced level 0, counter 0. Reset mid-sequence discards everything.
- Op encoding on alu_s:
  - 00 = add A+B
  - 01 = subtract A-B
  - 10 = shift A left by B
  - 11 = A AND B
  - All results are 4 bits; carries and borrows are dropped by the ALU.
- Button conditioning (per button):
  - Two-flop synchronizer.
  - Counter increments while the synchronized level differs from the debounced level and clears whenever they match.
  - When the counter reaches DB_CYCLES, the debounced level flips and the counter clears.
  - The step/clear pulse is debounced & ~debounced_prev: exactly one cycle per accepted press, none on release.
  - A bounce shorter than DB_CYCLES cycles produces no pulse.
- FSM states: S_A, S_B, S_OP, S_EXEC, S_SHOW.
  - S_A + step: a_q <= sw_data; go to S_B.
  - S_B + step: b_q <= sw_data; go to S_OP.
  - S_OP + step: op_q <= sw_data[1:0]; go to S_EXEC.
  - S_EXEC (exactly 1 cycle, no input needed): result_q <= alu_f; result_valid <= 1; go to S_SHOW. The ALU has seen the new op_q for one full cycle by then.
  - S_SHOW + step: result_valid <= 0; go to S_A. a_q, b_q, op_q and result_q are retained until overwritten.
  - Any state + clear pulse: same effect as reset, except the debouncers keep running.
  - Clear has priority over a simultaneous step.
- Step pulses arriving in S_EXEC are ignored (not queued).
- alu_a, alu_b and alu_s change only on the capturing edge; they never glitch otherwise.
- phase is decoded from state; S_EXEC shows 4'b0100.
- Press latency: a clean raw press at cycle 0 yields the step pulse at cycle DB_CYCLES+2. The capture takes effect at the following edge.
- sw_data bits [3:2] are ignored in S_OP.

Decomposition:
- Package alu_pkg:
  - state typedef enum logic [2:0] {S_A, S_B, S_OP, S_EXEC, S_SHOW}
  - localparams OP_ADD=2'b00, OP_SUB=2'b01, OP_SHL=2'b10, OP_AND=2'b11
  - phase one-hot constants
- One sub-module, btn_debounce: synchronizer + counter + edge pulse, parameterized by DB_CYCLES. Instantiated twice (step, clear).
- The FSM and datapath registers live in the top.

Test Plan (DB_CYCLES=4; bench drives alu_f from a behavioural ALU model):
- Reset → alu_a/alu_b/alu_s/result_q = 0, result_valid = 0, phase = 0001. Pulsing rst mid-S_OP returns to the same state.
- Enter sw 3, step; sw 5, step; sw 0, step → alu_a=3, alu_b=5, alu_s=00. Two cycles after the third pulse, result_q=8, result_valid=1, phase=1000.
- Same operands with op 01 → result_q=4'hE. Op 10 with A=3, B=1 → 6. Op 11 with A=4'hC, B=4'hA → 4'h8.
- Bouncy step: toggles of 1-3 cycles, then held → exactly one step pulse, exactly one phase advance. Releasing the button → no pulse.
- Clear and step accepted in the same cycle while in S_B → state S_A, a_q=0, result_valid=0.
- In S_SHOW, step → result_valid=0, phase=0001, result_q unchanged. A step held during S_EXEC produces no extra advance.
